// File: rtl/d8_mem_data_stage_pkg.sv
// d8_mem_data_stage_pkg: shared opcode constants, state encoding and default
// timeout for the dumb8 memory-access stage.
package d8_mem_data_stage_pkg;

  localparam logic [7:0] D8_OP_LD = 8'h07;
  localparam logic [7:0] D8_OP_ST = 8'h08;

  localparam int D8_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    D8_MS_IDLE   = 2'd0,
    D8_MS_ACCESS = 2'd1,
    D8_MS_RESULT = 2'd2
  } d8_ms_e;

  // The store flag wins over the opcode, so an instruction is a load only
  // when it is not also flagged as a store.
  function automatic logic d8_is_load(input logic w, input logic [7:0] op,
                                      input logic [7:0] load_op);
    return !w && (op == load_op);
  endfunction

endpackage

// File: rtl/d8_mem_timeout.sv
// d8_mem_timeout: wait counter for one memory access. Flags expiry on the
// cycle that would be the TIMEOUT_CYCLES-th ACCESS cycle without an ack.
module d8_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Clear on entry to ACCESS, count every ACCESS cycle that has no ack.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 8'h00;
    end else if (active && !ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the expiring cycle suppresses the timeout.
  assign expired = active && !ack && (cnt_q == LAST_CNT);

endmodule

// File: rtl/d8_mem_data_stage.sv
// d8_mem_data_stage: memory-access stage of the dumb8 core. One optional
// feature: define D8_MEM_TIMEOUT_EN to bound the wait for mem_ack.
module d8_mem_data_stage
  import d8_mem_data_stage_pkg::*;
#(
  parameter logic [7:0] LOAD_OP        = D8_OP_LD,
  parameter int         TIMEOUT_CYCLES = D8_TIMEOUT_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op,
  input  logic       w,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [2:0] rd_idx,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_rd_idx,
  output logic       out_wb_en,
  output logic       out_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("d8_mem_data_stage: TIMEOUT_CYCLES must be within 1..255");
  end

  d8_ms_e     state_q, state_d;
  logic       is_load_q, is_load_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [2:0] out_rd_idx_q, out_rd_idx_d;
  logic       out_wb_en_q, out_wb_en_d;
  logic       out_err_q, out_err_d;

  logic accept;
  logic is_mem_op;
  logic enter_access;
  logic timeout_hit;

  assign accept       = (state_q == D8_MS_IDLE) && in_valid;
  assign is_mem_op    = w || (op == LOAD_OP);
  assign enter_access = accept && is_mem_op;

`ifdef D8_MEM_TIMEOUT_EN
  d8_mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (enter_access),
    .active   (state_q == D8_MS_ACCESS),
    .ack      (mem_ack),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output logic for IDLE -> ACCESS -> RESULT.
  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rd_idx_d = out_rd_idx_q;
    out_wb_en_d  = out_wb_en_q;
    out_err_d    = out_err_q;
    case (state_q)
      D8_MS_IDLE: begin
        if (in_valid) begin
          is_load_d    = d8_is_load(w, op, LOAD_OP);
          mem_addr_d   = addr;
          mem_wdata_d  = wdata;
          out_rd_idx_d = rd_idx;
          out_err_d    = 1'b0;
          if (is_mem_op) begin
            state_d   = D8_MS_ACCESS;
            mem_req_d = 1'b1;
            mem_we_d  = w;
          end else begin
            state_d     = D8_MS_RESULT;
            out_valid_d = 1'b1;
            out_data_d  = 8'h00;
            out_wb_en_d = 1'b0;
          end
        end
      end
      D8_MS_ACCESS: begin
        if (mem_ack) begin
          state_d     = D8_MS_RESULT;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = is_load_q ? mem_rdata : 8'h00;
          out_wb_en_d = is_load_q;
        end else if (timeout_hit) begin
          state_d     = D8_MS_RESULT;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          out_wb_en_d = 1'b0;
          out_err_d   = 1'b1;
        end
      end
      D8_MS_RESULT: begin
        if (out_ready) begin
          state_d     = D8_MS_IDLE;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = D8_MS_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any access or pending beat.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= D8_MS_IDLE;
      is_load_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 8'h00;
      mem_wdata_q  <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_rd_idx_q <= 3'd0;
      out_wb_en_q  <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_idx_q <= out_rd_idx_d;
      out_wb_en_q  <= out_wb_en_d;
      out_err_q    <= out_err_d;
    end
  end

  assign in_ready   = (state_q == D8_MS_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_rd_idx = out_rd_idx_q;
  assign out_wb_en  = out_wb_en_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_d8_mem_data_stage.sv
// tb_d8_mem_data_stage: directed and randomized checks of the memory-access
// stage against a transaction-level model with a byte-array memory.
module tb_d8_mem_data_stage;
  import d8_mem_data_stage_pkg::*;

  localparam logic [7:0] LD  = 8'h07;
  localparam int         TMO = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op = 8'h00;
  logic       w = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [2:0] rd_idx = 3'd0;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_rd_idx;
  logic       out_wb_en;
  logic       out_err;

  int tests = 0;
  int fails = 0;
  logic [7:0] mem_model [256];

  d8_mem_data_stage #(
    .LOAD_OP       (LD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .w         (w),
    .addr      (addr),
    .wdata     (wdata),
    .rd_idx    (rd_idx),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd_idx(out_rd_idx),
    .out_wb_en (out_wb_en),
    .out_err   (out_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    $display("[TB] reset check %s", tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk8({tag, "_mem_addr"}, mem_addr, 8'h00);
    chk8({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk8({tag, "_out_data"}, out_data, 8'h00);
    chk8({tag, "_out_rd_idx"}, {5'd0, out_rd_idx}, 8'h00);
    chk1({tag, "_out_wb_en"}, out_wb_en, 1'b0);
    chk1({tag, "_out_err"}, out_err, 1'b0);
  endtask

  // One complete instruction: accept, optional memory access answered after
  // ack_dly extra cycles, then a result beat held for rdy_dly stall cycles.
  task automatic run_txn(input logic [7:0] op_i, input logic w_i,
                         input logic [7:0] addr_i, input logic [7:0] wdata_i,
                         input logic [2:0] rd_i, input int ack_dly, input int rdy_dly);
    logic       is_load;
    logic       is_mem;
    logic [7:0] exp_data;
    is_load  = !w_i && (op_i == LD);
    is_mem   = w_i || is_load;
    exp_data = is_load ? mem_model[addr_i] : 8'h00;
    $display("[TB] txn op=%h w=%b addr=%h wdata=%h rd=%0d ack_dly=%0d rdy_dly=%0d exp_data=%h wb=%b",
             op_i, w_i, addr_i, wdata_i, rd_i, ack_dly, rdy_dly, exp_data, is_load);
    chk1("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1;
    op = op_i;
    w = w_i;
    addr = addr_i;
    wdata = wdata_i;
    rd_idx = rd_i;
    tick;
    in_valid = 1'b0;
    op = 8'($urandom);
    w = 1'($urandom);
    addr = 8'($urandom);
    wdata = 8'($urandom);
    rd_idx = 3'($urandom);
    if (is_mem) begin
      for (int c = 0; c <= ack_dly; c++) begin
        chk1("mem_req_access", mem_req, 1'b1);
        chk1("mem_we_access", mem_we, w_i);
        chk8("mem_addr_access", mem_addr, addr_i);
        if (w_i) chk8("mem_wdata_access", mem_wdata, wdata_i);
        chk1("in_ready_access", in_ready, 1'b0);
        chk1("out_valid_access", out_valid, 1'b0);
        if (c == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = is_load ? mem_model[addr_i] : 8'($urandom);
        end else begin
          mem_rdata = 8'($urandom);
        end
        tick;
        mem_ack = 1'b0;
      end
      if (w_i) mem_model[addr_i] = wdata_i;
    end
    for (int r = 0; r <= rdy_dly; r++) begin
      chk1("mem_req_result", mem_req, 1'b0);
      chk1("out_valid_result", out_valid, 1'b1);
      chk8("out_data_result", out_data, exp_data);
      chk8("out_rd_idx_result", {5'd0, out_rd_idx}, {5'd0, rd_i});
      chk1("out_wb_en_result", out_wb_en, is_load);
      chk1("out_err_result", out_err, 1'b0);
      chk1("in_ready_result", in_ready, 1'b0);
      if (r == rdy_dly) begin
        out_ready = 1'b1;
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
      tick;
      out_ready = 1'b0;
      mem_ack = 1'b0;
    end
    chk1("out_valid_after_beat", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int max_ack;
    logic [7:0] rop;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);

    // Reset state
    sys_rst_n = 1'b0;
    tick;
    tick;
    check_reset_vals("por");
    sys_rst_n = 1'b1;
    tick;

    // Store with ack in its third request cycle
    run_txn(D8_OP_ST, 1'b1, 8'h20, 8'hA5, 3'd0, 2, 0);
    // Load returning 3C on a same-cycle ack
    mem_model[8'h10] = 8'h3C;
    run_txn(LD, 1'b0, 8'h10, 8'h00, 3'd5, 0, 0);
    // Non-memory opcode
    run_txn(8'h01, 1'b0, 8'h44, 8'h99, 3'd7, 0, 0);
    // Store flag wins over the load opcode
    run_txn(LD, 1'b1, 8'h10, 8'h5E, 3'd4, 1, 0);
    // Load sees the value written by the previous store, under backpressure
    run_txn(LD, 1'b0, 8'h10, 8'h00, 3'd3, 1, 4);
    run_txn(8'h02, 1'b0, 8'h01, 8'h02, 3'd1, 0, 4);

    // Reset in mid-ACCESS followed by a late ack
    in_valid = 1'b1; op = D8_OP_ST; w = 1'b1; addr = 8'h5A; wdata = 8'hC3; rd_idx = 3'd6;
    tick;
    in_valid = 1'b0;
    chk1("mid_rst_req_before", mem_req, 1'b1);
    tick;
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    check_reset_vals("mid_access");
    mem_ack = 1'b1;
    mem_rdata = 8'hFF;
    tick;
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk1("late_ack_no_valid", out_valid, 1'b0);
      chk1("late_ack_no_req", mem_req, 1'b0);
      tick;
    end

    // Reset while a beat waits in RESULT drops it
    in_valid = 1'b1; op = 8'h03; w = 1'b0; addr = 8'h11; rd_idx = 3'd2;
    tick;
    in_valid = 1'b0;
    chk1("result_before_rst", out_valid, 1'b1);
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    check_reset_vals("in_result");
    tick;
    chk1("dropped_beat", out_valid, 1'b0);

`ifdef D8_MEM_TIMEOUT_EN
    // Load with no ack times out after TMO request cycles
    $display("[TB] timeout load, no ack");
    in_valid = 1'b1; op = LD; w = 1'b0; addr = 8'h33; rd_idx = 3'd2;
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      chk1("tmo_req_high", mem_req, 1'b1);
      chk1("tmo_no_valid", out_valid, 1'b0);
      tick;
    end
    chk1("tmo_req_low", mem_req, 1'b0);
    chk1("tmo_valid", out_valid, 1'b1);
    chk1("tmo_err", out_err, 1'b1);
    chk1("tmo_wb_en", out_wb_en, 1'b0);
    chk8("tmo_data", out_data, 8'h00);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk1("tmo_err_cleared", out_err, 1'b0);
    chk1("tmo_valid_cleared", out_valid, 1'b0);
    run_txn(D8_OP_ST, 1'b1, 8'h34, 8'h77, 3'd1, 1, 0);
    // Ack in the expiring cycle still completes normally
    run_txn(LD, 1'b0, 8'h34, 8'h00, 3'd3, TMO - 1, 0);
    max_ack = TMO - 1;
`else
    max_ack = 6;
`endif

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    rop = LD;
        2:       rop = D8_OP_ST;
        default: rop = 8'($urandom);
      endcase
      run_txn(rop, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 15)), 8'($urandom),
              3'($urandom), $urandom_range(0, max_ack), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
